fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling buffer between the fetch stage and the decode pipeline register of the RV32 pipeline CPU. Captures each fetched {pc, predicted next pc, instruction} triple into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake. Absorbs decode stalls without back-pressuring the PC register every cycle, and discards all buffered work on a control-flow flush.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- XLEN, 32, width of pc, predicted pc and instruction fields
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- fetch_i_valid  in  1  fetch offers an entry this cycle
- fetch_i_pc  in  XLEN  pc of offered instruction
- fetch_i_pre_pc  in  XLEN  predicted next pc
- fetch_i_instr  in  XLEN  instruction word
- fetchq_o_ready  out  1  queue accepts an entry this cycle
- ctrl_i_flush  in  1  redirect/flush from execute; discard everything
- decode_i_ready  in  1  decode consumes the head entry this cycle
- fetchq_o_valid  out  1  head entry valid
- fetchq_o_pc  out  XLEN  head pc
- fetchq_o_pre_pc  out  XLEN  head predicted pc
- fetchq_o_instr  out  XLEN  head instruction
- fetchq_o_count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry array; wr_ptr and rd_ptr each $clog2(DEPTH)+1 bits (extra wrap bit).
- empty = (wr_ptr == rd_ptr); full = index bits equal and wrap bits differ.
- count = wr_ptr − rd_ptr, modulo 2^($clog2(DEPTH)+1).
- fetchq_o_ready = !full && !ctrl_i_flush.
- Enqueue when fetch_i_valid && fetchq_o_ready: write at wr_ptr index, wr_ptr+1.
- Dequeue when fetchq_o_valid && decode_i_ready: rd_ptr+1.
- Simultaneous enqueue and dequeue: both pointers advance; count unchanged. Allowed at any non-full occupancy. Enqueue while full is never accepted, even with same-cycle dequeue.
- Pointers wrap naturally through the wrap bit; no special case at index DEPTH−1→0.
- fetchq_o_valid = !empty && !ctrl_i_flush.
- fetchq_o_pc/pre_pc/instr = head entry when fetchq_o_valid, else 0.
- Flush: priority over enqueue and dequeue. Next cycle wr_ptr = rd_ptr = 0. Same-cycle fetch offer is dropped (ready low). Same-cycle head is not consumed (valid low).
- Reset: priority over flush. Pointers 0. Array contents are not cleared. Post-reset outputs: valid 0, ready 1, count 0, data 0. Reset mid-stream discards all entries.

## Timing
- Without bypass: entry enqueued at edge N is visible on fetchq_o_* after edge N (1-cycle latency). Sustained throughput is 1 entry/cycle.
- Flush asserted in cycle N: fetchq_o_valid low in N. Queue empty after edge N. First post-flush fetch accepted in N+1, visible in N+2.
- fetchq_o_ready depends only on registered state and ctrl_i_flush. It never depends on decode_i_ready, so there is no combinational path from decode ready to fetch.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when empty, fetch_i_valid high and no flush, fetchq_o_valid = 1 and fetchq_o_* = fetch_i_* in the same cycle.
  - If decode_i_ready is also high, the entry passes through and is not written; pointers are unchanged.
  - Otherwise it is enqueued normally.
  - Latency is 0 cycles when empty.
- Not defined: no fetch→decode combinational path; latency is always ≥1 cycle.

## Structure
- Package fetch_pkg:
  - XLEN constant
  - FETCHQ_DEPTH default
  - fetch_entry_t struct {pc, pre_pc, instr}
- Storage is fetch_entry_t [DEPTH].
- One sub-module, fetch_queue_mem: DEPTH×fetch_entry_t array with one synchronous write port and one asynchronous read port. Pointer, flag and handshake logic stays in fetch_queue.

## Test plan
- Reset, then fill: rst 1 cycle, then offer pc 0x0,0x4,0x8,0xC with decode_i_ready=0 → count 1,2,3,4, then ready 0. Fifth offer pc 0x10 is not accepted.
- Drain order: from full, decode_i_ready=1 for 4 cycles → fetchq_o_pc 0x0,0x4,0x8,0xC in order, then valid 0, count 0.
- Streaming with wrap: continuous offers pc 0x100+4k with decode_i_ready=1 for 20 cycles → count stays 1, outputs in order, pointers wrap cleanly. With bypass, count stays 0 and pc appears the same cycle.
- Flush mid-stream: count 3, assert ctrl_i_flush with fetch_i_valid=1 and decode_i_ready=1 → valid 0 and ready 0 that cycle, count 0 next cycle. A later offer of pc 0x200 is the next output.
- Simultaneous enq/deq at DEPTH−1: count 3, offer and consume the same cycle → count stays 3, head advances by one entry.
- Reset over flush: rst and ctrl_i_flush together with count 2 → count 0, valid 0, ready 1, data outputs 0 next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue: field width, default depth and the entry record.
package fetch_pkg;

  localparam int XLEN         = 32;
  localparam int FETCHQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pre_pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port, one asynchronous read port.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  fetch_entry_t  wdata_i,
  input  logic [IW-1:0] raddr_i,
  output fetch_entry_t  rdata_o
);

  // Contents are never cleared; the pointers alone decide what is valid.
  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Circular FIFO decoupling fetch from decode, with flush-to-empty.
// Optional same-cycle fetch->decode pass-through when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = fetch_pkg::FETCHQ_DEPTH,
  parameter int XLEN  = fetch_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_i_valid,
  input  logic [XLEN-1:0]          fetch_i_pc,
  input  logic [XLEN-1:0]          fetch_i_pre_pc,
  input  logic [XLEN-1:0]          fetch_i_instr,
  output logic                     fetchq_o_ready,
  input  logic                     ctrl_i_flush,
  input  logic                     decode_i_ready,
  output logic                     fetchq_o_valid,
  output logic [XLEN-1:0]          fetchq_o_pc,
  output logic [XLEN-1:0]          fetchq_o_pre_pc,
  output logic [XLEN-1:0]          fetchq_o_instr,
  output logic [$clog2(DEPTH):0]   fetchq_o_count
);
  import fetch_pkg::*;

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  fetch_entry_t  wr_ent, rd_ent, head;
  logic          empty, full, enq, deq;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);

  assign wr_ent = '{pc: fetch_i_pc, pre_pc: fetch_i_pre_pc, instr: fetch_i_instr};

  // Ready never looks at decode_i_ready, so decode stalls cannot reach fetch combinationally.
  assign fetchq_o_ready = !full && !ctrl_i_flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  assign byp            = empty && fetch_i_valid && !ctrl_i_flush;
  assign fetchq_o_valid = (!empty || fetch_i_valid) && !ctrl_i_flush;
  assign head           = byp ? wr_ent : rd_ent;
  // A bypassed entry that decode takes this cycle never touches storage.
  assign enq            = fetch_i_valid && fetchq_o_ready && !(byp && decode_i_ready);
  assign deq            = fetchq_o_valid && decode_i_ready && !byp;
`else
  assign fetchq_o_valid = !empty && !ctrl_i_flush;
  assign head           = rd_ent;
  assign enq            = fetch_i_valid && fetchq_o_ready;
  assign deq            = fetchq_o_valid && decode_i_ready;
`endif

  assign fetchq_o_pc     = fetchq_o_valid ? head.pc     : '0;
  assign fetchq_o_pre_pc = fetchq_o_valid ? head.pre_pc : '0;
  assign fetchq_o_instr  = fetchq_o_valid ? head.instr  : '0;
  assign fetchq_o_count  = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (ctrl_i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (enq),
    .waddr_i (wr_ptr_q[IW-1:0]),
    .wdata_i (wr_ent),
    .raddr_i (rd_ptr_q[IW-1:0]),
    .rdata_o (rd_ent)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, streaming/wrap loop, and random
// traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetch_i_valid;
  logic [XLEN-1:0] fetch_i_pc, fetch_i_pre_pc, fetch_i_instr;
  logic            fetchq_o_ready;
  logic            ctrl_i_flush;
  logic            decode_i_ready;
  logic            fetchq_o_valid;
  logic [XLEN-1:0] fetchq_o_pc, fetchq_o_pre_pc, fetchq_o_instr;
  logic [CW-1:0]   fetchq_o_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_i_valid   (fetch_i_valid),
    .fetch_i_pc      (fetch_i_pc),
    .fetch_i_pre_pc  (fetch_i_pre_pc),
    .fetch_i_instr   (fetch_i_instr),
    .fetchq_o_ready  (fetchq_o_ready),
    .ctrl_i_flush    (ctrl_i_flush),
    .decode_i_ready  (decode_i_ready),
    .fetchq_o_valid  (fetchq_o_valid),
    .fetchq_o_pc     (fetchq_o_pc),
    .fetchq_o_pre_pc (fetchq_o_pre_pc),
    .fetchq_o_instr  (fetchq_o_instr),
    .fetchq_o_count  (fetchq_o_count)
  );

  typedef struct {
    logic        rst, flush, fv, dr;
    logic [31:0] pc;
    logic        ev, er;
    int          ecnt;
    logic [31:0] epc;
  } vec_t;

  typedef struct {
    logic [31:0] pc, pre_pc, instr;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fl, input logic fv, input logic [31:0] pc,
                       input logic dr);
    rst            = r;
    ctrl_i_flush   = fl;
    fetch_i_valid  = fv;
    fetch_i_pc     = pc;
    fetch_i_pre_pc = pc + 32'd4;
    fetch_i_instr  = ~pc;
    decode_i_ready = dr;
  endtask

  vec_t vt[$];
  ent_t q[$];

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("reset_valid", {31'd0, fetchq_o_valid}, 32'd0);
    chk("reset_ready", {31'd0, fetchq_o_ready}, 32'd1);
    chk("reset_count", 32'(fetchq_o_count), 32'd0);
    chk("reset_pc",    fetchq_o_pc, 32'd0);

`ifndef FETCH_QUEUE_BYPASS_EN
    //     rst   flush fv    dr    pc          ev    er    cnt epc
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 0, 32'h00});
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h04, 1'b1, 1'b1, 1, 32'h00});
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h08, 1'b1, 1'b1, 2, 32'h00});
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0C, 1'b1, 1'b1, 3, 32'h00});
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 4, 32'h00});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 4, 32'h00});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 3, 32'h04});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 2, 32'h08});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 1, 32'h0C});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 0, 32'h00});
    // flush mid-stream at count 3
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 0, 32'h00});
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h24, 1'b1, 1'b1, 1, 32'h20});
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h28, 1'b1, 1'b1, 2, 32'h20});
    vt.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h2C, 1'b0, 1'b0, 3, 32'h00});
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 0, 32'h00});
    // simultaneous enq/deq at count 3
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h204, 1'b1, 1'b1, 1, 32'h200});
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h208, 1'b1, 1'b1, 2, 32'h200});
    vt.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'h20C, 1'b1, 1'b1, 3, 32'h200});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 3, 32'h204});
    // reset over flush at count 2
    vt.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 2, 32'h00});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 0, 32'h00});

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].flush, vt[i].fv, vt[i].pc, vt[i].dr);
      #1;
      chk($sformatf("tbl%0d_valid", i), {31'd0, fetchq_o_valid}, {31'd0, vt[i].ev});
      chk($sformatf("tbl%0d_ready", i), {31'd0, fetchq_o_ready}, {31'd0, vt[i].er});
      chk($sformatf("tbl%0d_count", i), 32'(fetchq_o_count), 32'(vt[i].ecnt));
      chk($sformatf("tbl%0d_pc", i), fetchq_o_pc, vt[i].epc);
      if (vt[i].ev) begin
        chk($sformatf("tbl%0d_prepc", i), fetchq_o_pre_pc, vt[i].epc + 32'd4);
        chk($sformatf("tbl%0d_instr", i), fetchq_o_instr, ~vt[i].epc);
      end
    end
`endif

    // streaming with wrap: 20 cycles of offer + consume from empty
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 32'h100 + 32'(4 * k), 1'b1);
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("stream_count", 32'(fetchq_o_count), 32'd0);
      chk("stream_valid", {31'd0, fetchq_o_valid}, 32'd1);
      chk("stream_pc", fetchq_o_pc, 32'h100 + 32'(4 * k));
`else
      chk("stream_count", 32'(fetchq_o_count), (k == 0) ? 32'd0 : 32'd1);
      chk("stream_valid", {31'd0, fetchq_o_valid}, (k == 0) ? 32'd0 : 32'd1);
      chk("stream_pc", fetchq_o_pc, (k == 0) ? 32'd0 : 32'h100 + 32'(4 * (k - 1)));
`endif
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);

    // random traffic against the reference model (queue starts empty after the reset above)
    q.delete();
    for (int c = 0; c < 2000; c++) begin
      logic r, fl, fv, dr, er, ev, byp, acc, con;
      ent_t in, eh;
      r  = ($urandom_range(0, 99) < 2);
      fl = ($urandom_range(0, 99) < 4);
      fv = ($urandom_range(0, 99) < 60);
      dr = ($urandom_range(0, 99) < 45);
      in.pc = $urandom; in.pre_pc = $urandom; in.instr = $urandom;
      rst = r; ctrl_i_flush = fl; fetch_i_valid = fv; decode_i_ready = dr;
      fetch_i_pc = in.pc; fetch_i_pre_pc = in.pre_pc; fetch_i_instr = in.instr;

      er = (q.size() < DEPTH) && !fl;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp = (q.size() == 0) && fv && !fl;
`else
      byp = 1'b0;
`endif
      ev = ((q.size() > 0) || byp) && !fl;
      eh = '{32'd0, 32'd0, 32'd0};
      if (ev) eh = byp ? in : q[0];

      #1;
      chk("rnd_ready", {31'd0, fetchq_o_ready}, {31'd0, er});
      chk("rnd_valid", {31'd0, fetchq_o_valid}, {31'd0, ev});
      chk("rnd_count", 32'(fetchq_o_count), 32'(q.size()));
      chk("rnd_pc",    fetchq_o_pc,     eh.pc);
      chk("rnd_prepc", fetchq_o_pre_pc, eh.pre_pc);
      chk("rnd_instr", fetchq_o_instr,  eh.instr);

      acc = fv && er;
      con = ev && dr;
      if (r || fl) q.delete();
      else if (!(byp && con)) begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(in);
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
